// File: rtl/alu_op_issuer.sv
// alu_op_issuer
//   Initiator side of the ALU operand/function interface. Accepts one command
//   at a time, reads two source registers from an internal 8-entry register
//   file into registered ALU operands, captures the combinational ALU result
//   and flags, and writes the result back.
// Ports
//   clk, reset            clock, async active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op/rd/rs/rt/imm   command fields (op: ADD SUB AND OR XOR LDI, 6-7 illegal)
//   alu_a/alu_b/alu_function   registered drive into the ALU
//   alu_result/zero/sign/ovf   combinational ALU response
//   done, err             one-cycle retire pulse, err on illegal op
//   flag_z/flag_s/flag_v  last captured ALU flags
//   dbg_addr/dbg_data     combinational register-file read port
module alu_op_issuer #(
  parameter int DW    = 8,
  parameter int RF_AW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [RF_AW-1:0] cmd_rd,
  input  logic [RF_AW-1:0] cmd_rs,
  input  logic [RF_AW-1:0] cmd_rt,
  input  logic [DW-1:0]    cmd_imm,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic [3:0]       alu_function,
  input  logic [DW-1:0]    alu_result,
  input  logic             alu_zero,
  input  logic             alu_sign,
  input  logic             alu_ovf,
  output logic             done,
  output logic             err,
  output logic             flag_z,
  output logic             flag_s,
  output logic             flag_v,
  input  logic [RF_AW-1:0] dbg_addr,
  output logic [DW-1:0]    dbg_data
);

  localparam int NREG = 2**RF_AW;
  localparam logic [2:0] OP_LDI = 3'd5;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WRITEBACK} state_t;

  state_t           r_state, w_next;
  logic [DW-1:0]    r_rf [NREG];
  logic [2:0]       r_op;
  logic [RF_AW-1:0] r_rd;
  logic [DW-1:0]    r_imm;
  logic [DW-1:0]    r_res;
  logic             r_z, r_s, r_v;
  logic [DW-1:0]    w_rs_data, w_rt_data;
  logic             w_is_alu;

  // r0 is hardwired to zero on every read path
  assign w_rs_data = (cmd_rs   == '0) ? '0 : r_rf[cmd_rs];
  assign w_rt_data = (cmd_rt   == '0) ? '0 : r_rf[cmd_rt];
  assign dbg_data  = (dbg_addr == '0) ? '0 : r_rf[dbg_addr];

  assign w_is_alu  = (r_op <= 3'd4);
  assign cmd_ready = (r_state == IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (cmd_valid) w_next = ISSUE;
      ISSUE:     w_next = CAPTURE;
      CAPTURE:   w_next = WRITEBACK;
      WRITEBACK: w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_op         <= '0;
      r_rd         <= '0;
      r_imm        <= '0;
      r_res        <= '0;
      r_z          <= 1'b0;
      r_s          <= 1'b0;
      r_v          <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_function <= 4'h0;
      done         <= 1'b0;
      err          <= 1'b0;
      flag_z       <= 1'b0;
      flag_s       <= 1'b0;
      flag_v       <= 1'b0;
    end else begin
      r_state <= w_next;
      done    <= 1'b0;
      err     <= 1'b0;
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_op  <= cmd_op;
          r_rd  <= cmd_rd;
          r_imm <= cmd_imm;
          alu_a <= w_rs_data;
          alu_b <= w_rt_data;
          // LDI and illegal ops leave the ALU function code untouched
          if (cmd_op <= 3'd4) alu_function <= {1'b0, cmd_op};
        end
        CAPTURE: if (w_is_alu) begin
          r_res <= alu_result;
          r_z   <= alu_zero;
          r_s   <= alu_sign;
          r_v   <= alu_ovf;
        end
        WRITEBACK: begin
          // done is registered so it lines up with the rf/flag update
          done <= 1'b1;
          if (w_is_alu) begin
            if (r_rd != '0) r_rf[r_rd] <= r_res;
            flag_z <= r_z;
            flag_s <= r_s;
            flag_v <= r_v;
          end else if (r_op == OP_LDI) begin
            if (r_rd != '0) r_rf[r_rd] <= r_imm;
          end else begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
module tb_alu_op_issuer;
  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op, cmd_rd, cmd_rs, cmd_rt;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_function;
  logic       alu_zero, alu_sign, alu_ovf;
  logic       done, err, flag_z, flag_s, flag_v;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_op_issuer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_function(alu_function),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .alu_ovf(alu_ovf),
    .done(done), .err(err),
    .flag_z(flag_z), .flag_s(flag_s), .flag_v(flag_v),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Combinational 8-bit ALU the issuer drives
  always_comb begin
    alu_result = 8'h00;
    alu_ovf    = 1'b0;
    case (alu_function)
      4'h0: begin
        alu_result = alu_a + alu_b;
        alu_ovf = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      4'h1: begin
        alu_result = alu_a - alu_b;
        alu_ovf = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      4'h2: alu_result = alu_a & alu_b;
      4'h3: alu_result = alu_a | alu_b;
      4'h4: alu_result = alu_a ^ alu_b;
      default: alu_result = 8'h00;
    endcase
    alu_zero = (alu_result == 8'h00);
    alu_sign = alu_result[7];
  end

  task automatic rd_rf(input logic [2:0] a, output logic [7:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  // Drive one command from IDLE; report done latency, err and ISSUE-cycle function
  task automatic issue(input logic [2:0] op, rd, rs, rt, input logic [7:0] imm,
                       output int lat, output logic e, output logic [3:0] fn);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = -1; e = 1'b0; fn = 4'hx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) fn = alu_function;
      if (done) begin lat = i; e = err; break; end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 0; cmd_rd = 0; cmd_rs = 0; cmd_rt = 0;
    cmd_imm = 0; dbg_addr = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, done, err, flag_z, flag_s, flag_v} !== 6'b100000) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 100000",
                        {cmd_ready, done, err, flag_z, flag_s, flag_v});
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_function} !== 20'h0) begin
      n_bad++; $display("FAIL reset_alu got %h want 0", {alu_a, alu_b, alu_function});
    end
    for (int r = 0; r < 8; r++) begin
      rd_rf(3'(r), d);
      n_cmp++;
      if (d !== 8'h00) begin n_bad++; $display("FAIL reset_rf r%0d got %h want 00", r, d); end
    end
  endtask

  task automatic test_reset_mid_capture();
    int lat; logic e; logic [3:0] fn; logic [7:0] d; int dn;
    issue(3'd5, 3'd1, 3'd0, 3'd0, 8'h55, lat, e, fn);
    // ADD r1 = r1 + r1, then reset while in CAPTURE
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rd = 3'd1; cmd_rs = 3'd1; cmd_rt = 3'd1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready got %b want 1", cmd_ready); end
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    n_cmp++;
    if (dn != 0) begin n_bad++; $display("FAIL rst_mid_done got %0d pulses want 0", dn); end
    rd_rf(3'd1, d);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL rst_mid_r1 got %h want 00", d); end
  endtask

  task automatic test_add_ovf();
    int lat; logic e; logic [3:0] fn; logic [7:0] d;
    issue(3'd5, 3'd1, 3'd0, 3'd0, 8'h7F, lat, e, fn);
    n_cmp++;
    if (lat != 4) begin n_bad++; $display("FAIL ldi_latency got %0d want 4", lat); end
    issue(3'd5, 3'd2, 3'd0, 3'd0, 8'h01, lat, e, fn);
    issue(3'd0, 3'd3, 3'd1, 3'd2, 8'h00, lat, e, fn);
    n_cmp++;
    if (lat != 4 || e !== 1'b0) begin
      n_bad++; $display("FAIL add_done got lat=%0d err=%b want lat=4 err=0", lat, e);
    end
    rd_rf(3'd3, d);
    n_cmp++;
    if (d !== 8'h80) begin n_bad++; $display("FAIL add_r3 got %h want 80", d); end
    n_cmp++;
    if ({flag_z, flag_s, flag_v} !== 3'b011) begin
      n_bad++; $display("FAIL add_flags zsv got %b want 011", {flag_z, flag_s, flag_v});
    end
  endtask

  task automatic test_sub_zero();
    int lat; logic e; logic [3:0] fn; logic [7:0] d;
    issue(3'd1, 3'd4, 3'd1, 3'd1, 8'h00, lat, e, fn);
    n_cmp++;
    if (fn !== 4'h1) begin n_bad++; $display("FAIL sub_function got %h want 1", fn); end
    rd_rf(3'd4, d);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL sub_r4 got %h want 00", d); end
    n_cmp++;
    if ({flag_z, flag_s, flag_v} !== 3'b100) begin
      n_bad++; $display("FAIL sub_flags zsv got %b want 100", {flag_z, flag_s, flag_v});
    end
  endtask

  task automatic test_xor_r0();
    int lat; logic e; logic [3:0] fn; logic [7:0] d;
    issue(3'd5, 3'd5, 3'd0, 3'd0, 8'hF0, lat, e, fn);
    issue(3'd4, 3'd0, 3'd5, 3'd1, 8'h00, lat, e, fn);
    rd_rf(3'd0, d);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL xor_r0 got %h want 00", d); end
    n_cmp++;
    if ({flag_z, flag_s, flag_v} !== 3'b010) begin
      n_bad++; $display("FAIL xor_flags zsv got %b want 010", {flag_z, flag_s, flag_v});
    end
  endtask

  task automatic test_illegal();
    int lat; logic e; logic [3:0] fn; logic [7:0] d;
    issue(3'd7, 3'd3, 3'd1, 3'd2, 8'h00, lat, e, fn);
    n_cmp++;
    if (lat != 4 || e !== 1'b1) begin
      n_bad++; $display("FAIL illegal_done got lat=%0d err=%b want lat=4 err=1", lat, e);
    end
    rd_rf(3'd3, d);
    n_cmp++;
    if (d !== 8'h80) begin n_bad++; $display("FAIL illegal_r3 got %h want 80", d); end
    n_cmp++;
    if ({flag_z, flag_s, flag_v} !== 3'b010) begin
      n_bad++; $display("FAIL illegal_flags zsv got %b want 010", {flag_z, flag_s, flag_v});
    end
    n_cmp++;
    if (alu_function !== 4'h4) begin
      n_bad++; $display("FAIL illegal_function got %h want 4", alu_function);
    end
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL illegal_pulse_width got done=%b err=%b want 0 0", done, err);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$]; int dn; logic [7:0] d;
    dn = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
      cmd_valid = (i < 12);
      cmd_op = 3'd0; cmd_rs = 3'd6; cmd_rt = 3'd2; cmd_imm = 8'h00;
      // rd changes while busy; those cycles must be ignored
      cmd_rd = cmd_ready ? 3'd6 : 3'd7;
      if (cmd_valid && cmd_ready) acc.push_back(i);
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (acc.size() != 3) begin
      n_bad++; $display("FAIL b2b_accepts got %0d want 3", acc.size());
    end else begin
      n_cmp++;
      if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
        n_bad++; $display("FAIL b2b_spacing got %0d,%0d want 4,4", acc[1]-acc[0], acc[2]-acc[1]);
      end
    end
    n_cmp++;
    if (dn != 3) begin n_bad++; $display("FAIL b2b_done_count got %0d want 3", dn); end
    rd_rf(3'd6, d);
    n_cmp++;
    if (d !== 8'h03) begin n_bad++; $display("FAIL b2b_r6 got %h want 03", d); end
    rd_rf(3'd7, d);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL b2b_r7 got %h want 00", d); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_capture();
    test_add_ovf();
    test_sub_zero();
    test_xor_r0();
    test_illegal();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
